// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared funct3 codes, FSM state type and access-size helper for the data memory
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        RESPOND = 2'd2
    } dmem_state_t;

    // Size is carried by the low two funct3 bits for both loads and stores.
    function automatic logic [3:0] access_bytes(input logic [2:0] funct3);
        logic [3:0] bytes;
        case (funct3[1:0])
            2'd0:    bytes = 4'd1;
            2'd1:    bytes = 4'd2;
            2'd2:    bytes = 4'd4;
            default: bytes = 4'd8;
        endcase
        return bytes;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// rtl/dmem_lane_unit.sv - byte-lane enables/shift for stores, extract and extend for loads
module dmem_lane_unit
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  byte_offset,
    input  logic [63:0] store_data,
    input  logic [63:0] ram_word,
    output logic [7:0]  byte_en,
    output logic [63:0] write_word,
    output logic [63:0] load_data
);

    logic [7:0]  size_mask;
    logic [63:0] shifted;

    always_comb begin
        size_mask = 8'h00;
        case (funct3[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0f;
            default: size_mask = 8'hff;
        endcase
        byte_en    = size_mask << byte_offset;
        write_word = store_data << {byte_offset, 3'b000};
        shifted    = ram_word >> {byte_offset, 3'b000};

        // Codes outside the load table (LD and the reserved 111) return the whole word.
        load_data = shifted;
        case (funct3)
            F3_B:    load_data = {{56{shifted[7]}},  shifted[7:0]};
            F3_H:    load_data = {{48{shifted[15]}}, shifted[15:0]};
            F3_W:    load_data = {{32{shifted[31]}}, shifted[31:0]};
            F3_BU:   load_data = {56'd0, shifted[7:0]};
            F3_HU:   load_data = {48'd0, shifted[15:0]};
            F3_WU:   load_data = {32'd0, shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - multi-cycle load/store responder on a 64-bit word RAM; DMEM_ERROR_EN enables fault checks
module data_memory_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 512,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [63:0] req_address,
    input  logic [63:0] req_write_data,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_read_data,
    output logic        resp_error
);

    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    dmem_state_t state;
    logic [3:0]  wait_cnt;
    logic        cap_write;
    logic [2:0]  cap_funct3;
    logic [63:0] cap_address;
    logic [63:0] cap_write_data;

    logic [63:0] mem [DEPTH_WORDS];

    logic        acc_write;
    logic [2:0]  acc_funct3;
    logic [63:0] acc_address;
    logic [63:0] acc_write_data;
    logic [3:0]  acc_size;
    logic [60:0] word_num;
    logic [IDX_W-1:0] word_idx;
    logic [2:0]  byte_offset;
    logic        acc_err;
    logic        accept;
    logic        commit;
    logic [7:0]  byte_en;
    logic [63:0] write_word;
    logic [63:0] load_data;

    // With LATENCY=0 the access happens on the accept edge, so it must use the live request.
    always_comb begin
        acc_write      = (state == WAIT) ? cap_write      : req_write;
        acc_funct3     = (state == WAIT) ? cap_funct3     : req_funct3;
        acc_address    = (state == WAIT) ? cap_address    : req_address;
        acc_write_data = (state == WAIT) ? cap_write_data : req_write_data;
        acc_size       = access_bytes(acc_funct3);
        word_num       = acc_address[63:3];
`ifdef DMEM_ERROR_EN
        acc_err     = ((acc_address[2:0] & 3'(acc_size - 4'd1)) != 3'd0)
                    || (word_num >= 61'(DEPTH_WORDS))
                    || (acc_write ? acc_funct3[2] : (acc_funct3 == 3'b111));
        word_idx    = word_num[IDX_W-1:0];
        byte_offset = acc_address[2:0];
`else
        acc_err     = 1'b0;
        word_idx    = IDX_W'(word_num % 61'(DEPTH_WORDS));
        byte_offset = acc_address[2:0] & ~3'(acc_size - 4'd1);
`endif
    end

    assign accept = (state == IDLE) && req_valid && req_ready;
    assign commit = (LATENCY == 0) ? accept : ((state == WAIT) && (wait_cnt == 4'd0));

    dmem_lane_unit u_lane (
        .funct3      (acc_funct3),
        .byte_offset (byte_offset),
        .store_data  (acc_write_data),
        .ram_word    (mem[word_idx]),
        .byte_en     (byte_en),
        .write_word  (write_word),
        .load_data   (load_data)
    );

    // RAM is not reset; a reset arriving before commit must suppress the write.
    always_ff @(posedge clock) begin
        if (reset_n && commit && acc_write && !acc_err) begin
            for (int i = 0; i < 8; i++) begin
                if (byte_en[i]) begin
                    mem[word_idx][i*8 +: 8] <= write_word[i*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            req_ready      <= 1'b1;
            resp_valid     <= 1'b0;
            resp_read_data <= 64'd0;
            resp_error     <= 1'b0;
            wait_cnt       <= 4'd0;
            cap_write      <= 1'b0;
            cap_funct3     <= 3'd0;
            cap_address    <= 64'd0;
            cap_write_data <= 64'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cap_write      <= req_write;
                        cap_funct3     <= req_funct3;
                        cap_address    <= req_address;
                        cap_write_data <= req_write_data;
                        req_ready      <= 1'b0;
                        if (LATENCY == 0) begin
                            state          <= RESPOND;
                            resp_valid     <= 1'b1;
                            resp_error     <= acc_err;
                            resp_read_data <= (acc_write || acc_err) ? 64'd0 : load_data;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == 4'd0) begin
                        state          <= RESPOND;
                        resp_valid     <= 1'b1;
                        resp_error     <= acc_err;
                        resp_read_data <= (acc_write || acc_err) ? 64'd0 : load_data;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESPOND: begin
                    if (resp_ready) begin
                        state          <= IDLE;
                        resp_valid     <= 1'b0;
                        req_ready      <= 1'b1;
                        resp_read_data <= 64'd0;
                        resp_error     <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_memory_responder.sv
// tb/tb_data_memory_responder.sv - randomized self-checking bench against a byte-array memory model
module tb_data_memory_responder;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [63:0] req_address = 64'd0, req_write_data = 64'd0;
    logic        req_ready, resp_valid, resp_error;
    logic [63:0] resp_read_data;

    logic        z_req_valid = 1'b0, z_resp_ready = 1'b1;
    logic        z_req_ready, z_resp_valid, z_resp_error;
    logic [63:0] z_resp_read_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_m [DEPTH*8];

    always #5 clock = ~clock;

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_funct3(req_funct3), .req_address(req_address), .req_write_data(req_write_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_read_data(resp_read_data), .resp_error(resp_error)
    );

    data_memory_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_z (
        .clock(clock), .reset_n(reset_n),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(1'b0),
        .req_funct3(3'b011), .req_address(64'd0), .req_write_data(64'd0),
        .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
        .resp_read_data(z_resp_read_data), .resp_error(z_resp_error)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model(input logic w, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] d, output logic [63:0] rd, output logic er);
        int size;
        int base;
        size = 1 << f3[1:0];
        rd = 64'd0;
        er = 1'b0;
`ifdef DMEM_ERROR_EN
        if (w ? f3[2] : (f3 == 3'b111)) er = 1'b1;
        if (a % 64'(size) != 64'd0) er = 1'b1;
        if ((a >> 3) >= 64'(DEPTH)) er = 1'b1;
        if (er) return;
        base = int'(a);
`else
        base = int'(((a >> 3) % 64'(DEPTH)) * 8) + int'(a % 64'd8) / size * size;
`endif
        if (w) begin
            for (int i = 0; i < size; i++) mem_m[base+i] = d[8*i +: 8];
        end else begin
            for (int i = 0; i < size; i++) rd[8*i +: 8] = mem_m[base+i];
            if (!f3[2] && size < 8 && rd[8*size-1])
                for (int i = size; i < 8; i++) rd[8*i +: 8] = 8'hff;
        end
    endtask

    task automatic txn(input logic w, input logic [2:0] f3, input logic [63:0] a,
                       input logic [63:0] d, input int hold,
                       output logic [63:0] got, output logic got_err);
        logic [63:0] exp_d;
        logic        exp_e;
        int n;
        int lat;
        @(negedge clock);
        req_write = w; req_funct3 = f3; req_address = a; req_write_data = d;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clock); n++; end
        check("accept_timeout", 64'(n < 20), 64'd1);
        @(posedge clock);
        model(w, f3, a, d, exp_d, exp_e);
        #1 req_valid = 1'b0;
        lat = 0;
        do begin @(negedge clock); lat++; end while (!resp_valid && lat < 20);
        check("latency", 64'(lat), 64'(LAT + 1));
        check("resp_error", 64'(resp_error), 64'(exp_e));
        check("resp_data", resp_read_data, exp_d);
        got = resp_read_data;
        got_err = resp_error;
        for (int k = 0; k < hold; k++) begin
            req_valid = 1'b1;
            req_address = {$urandom, $urandom};
            @(negedge clock);
            check("bp_req_ready", 64'(req_ready), 64'd0);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_data", resp_read_data, exp_d);
            check("bp_error", 64'(resp_error), 64'(exp_e));
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock);
        #1 resp_ready = 1'b0;
        check("resp_valid_drop", 64'(resp_valid), 64'd0);
    endtask

    initial begin
        logic [63:0] g;
        logic        e;
        logic [2:0]  f3;
        logic [63:0] a;
        int size;
        int cnt;
        logic prev_rdy;

        repeat (3) @(negedge clock);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data", resp_read_data, 64'd0);
        check("rst_resp_error", 64'(resp_error), 64'd0);
        reset_n = 1'b1;

        for (int w = 0; w < DEPTH; w++)
            txn(1'b1, 3'b011, 64'(w * 8), {$urandom, $urandom}, 0, g, e);

        txn(1'b1, 3'b011, 64'h40, 64'h1122334455667788, 0, g, e);
        txn(1'b0, 3'b011, 64'h40, 64'd0, 0, g, e);
        check("ld_40", g, 64'h1122334455667788);
        txn(1'b1, 3'b000, 64'h43, 64'h80, 0, g, e);
        txn(1'b0, 3'b000, 64'h43, 64'd0, 0, g, e);
        check("lb_43", g, 64'hffffffffffffff80);
        txn(1'b0, 3'b100, 64'h43, 64'd0, 0, g, e);
        check("lbu_43", g, 64'h80);
        txn(1'b0, 3'b011, 64'h40, 64'd0, 5, g, e);
        check("ld_40_sb", g, 64'h1122334480667788);

`ifdef DMEM_ERROR_EN
        txn(1'b0, 3'b010, 64'h42, 64'd0, 0, g, e);
        check("lw_mis_err", 64'(e), 64'd1);
        check("lw_mis_data", g, 64'd0);
        txn(1'b1, 3'b011, 64'(8 * DEPTH), 64'hdeadbeefcafef00d, 0, g, e);
        check("sd_oor_err", 64'(e), 64'd1);
`else
        txn(1'b0, 3'b010, 64'h42, 64'd0, 0, g, e);
        txn(1'b1, 3'b011, 64'(8 * DEPTH), 64'hdeadbeefcafef00d, 0, g, e);
`endif
        txn(1'b0, 3'b011, 64'h0, 64'd0, 0, g, e);

        for (int i = 0; i < 150; i++) begin
            f3 = 3'($urandom_range(0, 7));
            size = 1 << f3[1:0];
            case ($urandom_range(0, 7))
                6:       a = 64'($urandom_range(0, DEPTH * 8 - 1));
                7:       a = {$urandom, $urandom};
                default: a = 64'($urandom_range(0, DEPTH * 8 - 1)) & ~64'(size - 1);
            endcase
            txn(1'($urandom_range(0, 1)), f3, a, {$urandom, $urandom},
                $urandom_range(0, 2), g, e);
        end

        // Reset while a store to 0x10 is still waiting: RAM must keep its old word.
        @(negedge clock);
        req_write = 1'b1; req_funct3 = 3'b011; req_address = 64'h10;
        req_write_data = 64'h0badc0de0badc0de; req_valid = 1'b1;
        @(posedge clock);
        #1 req_valid = 1'b0;
        @(negedge clock);
        check("wait_req_ready", 64'(req_ready), 64'd0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_req_ready", 64'(req_ready), 64'd1);
        check("mid_rst_resp_valid", 64'(resp_valid), 64'd0);
        check("mid_rst_resp_data", resp_read_data, 64'd0);
        check("mid_rst_resp_error", 64'(resp_error), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        txn(1'b0, 3'b011, 64'h10, 64'd0, 0, g, e);

        @(negedge clock);
        z_req_valid = 1'b1;
        prev_rdy = z_req_ready;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            check("l0_valid", 64'(z_resp_valid), 64'(prev_rdy));
            if (z_resp_valid) check("l0_error", 64'(z_resp_error), 64'd0);
            cnt += int'(z_resp_valid);
            prev_rdy = z_req_ready;
        end
        check("l0_count", 64'(cnt), 64'd6);
        z_req_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
